stream_demux_1_4: RTL and testbench
===================================

Name: stream_demux_1_4

Overview:
- Demultiplexer counterpart of the 4:1 data mux: one input stream is steered to one of four output channels by a 2-bit select carried with each word.
- Each output channel has a one-entry register slice, so a stalled channel holds only its own word; the other channels keep flowing.
- Sits between a single producer and four consumers, all using valid/ready handshakes, on one clock domain.

Parameters:
- W, 4, data width per word (any value >= 1).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, producer has a word.
- in_ready, output, 1, demux accepts the word this cycle.
- in_data, input, W, word to route.
- in_sel, input, 2, destination channel 0..3.
- d0_valid, d1_valid, d2_valid, d3_valid, output, 1 each, channel holds a word.
- d0_ready, d1_ready, d2_ready, d3_ready, input, 1 each, consumer takes the word.
- d0, d1, d2, d3, output, W each, channel data.

Behaviour:
- Reset is asynchronous, active-low and fixed: while rst_n=0, all dN_valid=0 and all dN=0, whatever the clock does. The first transfer can occur on the first rising edge after rst_n rises.
- Per channel i, state is vld_i and dat_i. Outputs are driven directly from these registers; there is no combinational path from in_* to dN*.
- in_ready = !vld[in_sel] | dN_ready[in_sel]. This is combinational and depends only on the selected channel.
- in_ready does not depend on in_valid. in_ready may depend on in_sel.
- Accept on a cycle where in_valid & in_ready.
- Load: on an accept, channel in_sel captures in_data and sets vld.
- Drain: channel i clears vld when vld_i & di_ready and channel i is not loaded in the same cycle.
- Simultaneous drain and load on the same channel: vld stays 1, dat takes the new word. This gives full throughput of 1 word/cycle per channel.
- Latency: an accepted word appears on dN one cycle after the accept edge.
- Channels not selected are unaffected by input activity; each drains independently.
- Head-of-line blocking: if the selected channel is full and its consumer is not ready, in_ready=0. The producer must hold in_valid, in_data and in_sel stable until accepted.
- dN must not change while dN_valid=1 and dN_ready=0.
- dN_valid never drops without a handshake.
- in_sel is ignored when in_valid=0.
- Ordering: words to the same channel leave in acceptance order.
- Reset asserted mid-operation: all buffered words are discarded immediately and every dN_valid clears asynchronously.

Optional Feature:
- Macro: STREAM_DEMUX_COUNT_EN.
- Defined: adds output ports cnt0, cnt1, cnt2, cnt3, each 8 bits.
  - cntN increments on every channel-N output handshake (dN_valid & dN_ready).
  - Counters wrap 255 -> 0 and reset to 0 on rst_n=0.
  - A counter value reflects handshakes completed before the current edge.
- Not defined: no counter ports and no counter logic; the datapath behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release -> all dN_valid=0, all dN=0, in_ready=1 for every in_sel.
- Single route: in_data=4'hA, in_sel=2, all dN_ready=0 -> next cycle d2_valid=1 and d2=4'hA; other dN_valid=0.
  - A second word to sel=2 -> in_ready=0.
  - A word to sel=1 -> accepted.
- Streaming: all dN_ready=1, 8 words 0..7 with in_sel=i%4, in_valid held high -> in_ready stays 1 every cycle; each channel sees its two words in order, each one cycle after its accept.
- Back-pressure on one channel: d3_ready=0 with d3 full, producer drives sel=3, word 4'h5 -> in_ready=0 and the word is held. Raise d3_ready -> the old word drains and 4'h5 loads on the same edge; d3_valid stays 1, then d3=4'h5.
- Mid-operation reset: load channels 0 and 1, pulse rst_n low between edges -> d0_valid and d1_valid fall immediately without a clock; no stale word appears after release.
- With STREAM_DEMUX_COUNT_EN: send 260 words to channel 0 with d0_ready=1 -> cnt0=4; cnt1, cnt2, cnt3 stay 0.

Source files
------------

// File: rtl/stream_demux_1_4.sv
// Steers one valid/ready stream to one of four channels by per-word select; optional STREAM_DEMUX_COUNT_EN adds per-channel handshake counters.
// Latency: one cycle from accept edge to dN; outputs come straight from per-channel registers.
// Backpressure: in_ready follows only the selected channel (empty or draining), so a stalled channel blocks just its own words.
module stream_demux_1_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic         d0_valid,
    output logic         d1_valid,
    output logic         d2_valid,
    output logic         d3_valid,
    input  logic         d0_ready,
    input  logic         d1_ready,
    input  logic         d2_ready,
    input  logic         d3_ready,
    output logic [W-1:0] d0,
    output logic [W-1:0] d1,
    output logic [W-1:0] d2,
`ifdef STREAM_DEMUX_COUNT_EN
    output logic [W-1:0] d3,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1,
    output logic [7:0]   cnt2,
    output logic [7:0]   cnt3
`else
    output logic [W-1:0] d3
`endif
);

    logic [3:0]   r_vld;
    logic [W-1:0] r_dat [4];
    logic [3:0]   w_rdy;
    logic [3:0]   w_load;
    logic [3:0]   w_hs;
    logic         w_acc;

    assign w_rdy    = {d3_ready, d2_ready, d1_ready, d0_ready};
    assign in_ready = !r_vld[in_sel] || w_rdy[in_sel];
    assign w_acc    = in_valid && in_ready;
    assign w_hs     = r_vld & w_rdy;

    always_comb begin
        w_load = 4'b0000;
        if (w_acc) begin
            w_load[in_sel] = 1'b1;
        end
    end

    // A load on a draining channel keeps vld high, giving one word per cycle per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= 1'b1;
                    r_dat[i] <= in_data;
                end else if (w_hs[i]) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    end

    assign d0_valid = r_vld[0];
    assign d1_valid = r_vld[1];
    assign d2_valid = r_vld[2];
    assign d3_valid = r_vld[3];
    assign d0       = r_dat[0];
    assign d1       = r_dat[1];
    assign d2       = r_dat[2];
    assign d3       = r_dat[3];

`ifdef STREAM_DEMUX_COUNT_EN
    logic [7:0] r_cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_hs[i]) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
    assign cnt3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed bench for stream_demux_1_4: vector table plus reset and counter sequences.
module tb_stream_demux_1_4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic       d0_valid, d1_valid, d2_valid, d3_valid;
    logic       d0_ready, d1_ready, d2_ready, d3_ready;
    logic [3:0] d0, d1, d2, d3;
`ifdef STREAM_DEMUX_COUNT_EN
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

    int total = 0;
    int bad   = 0;

    stream_demux_1_4 #(.W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .d0_valid (d0_valid),
        .d1_valid (d1_valid),
        .d2_valid (d2_valid),
        .d3_valid (d3_valid),
        .d0_ready (d0_ready),
        .d1_ready (d1_ready),
        .d2_ready (d2_ready),
        .d3_ready (d3_ready),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
`ifdef STREAM_DEMUX_COUNT_EN
        .d3       (d3),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
`else
        .d3       (d3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [3:0]  dat;
        logic [3:0]  rdy;      // {d3,d2,d1,d0}_ready
        logic        exp_ir;
        logic [3:0]  exp_vld;  // {d3,d2,d1,d0}_valid after the edge
        logic [15:0] exp_d;    // {d3,d2,d1,d0} after the edge
    } vec_t;

    vec_t vec [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] vld_bus();
        return {d3_valid, d2_valid, d1_valid, d0_valid};
    endfunction

    function automatic logic [15:0] dat_bus();
        return {d3, d2, d1, d0};
    endfunction

    task automatic set_rdy(input logic [3:0] r);
        {d3_ready, d2_ready, d1_ready, d0_ready} = r;
    endtask

    initial begin
        //                v     sel   dat   rdy      ir    vld      d
        vec[0]  = '{1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, 4'b0100, 16'h0A00};
        vec[1]  = '{1'b1, 2'd2, 4'hB, 4'b0000, 1'b0, 4'b0100, 16'h0A00};
        vec[2]  = '{1'b1, 2'd1, 4'hC, 4'b0000, 1'b1, 4'b0110, 16'h0AC0};
        vec[3]  = '{1'b0, 2'd2, 4'hF, 4'b0100, 1'b1, 4'b0010, 16'h0AC0};
        vec[4]  = '{1'b0, 2'd0, 4'hF, 4'b0010, 1'b1, 4'b0000, 16'h0AC0};
        vec[5]  = '{1'b1, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0001, 16'h0AC0};
        vec[6]  = '{1'b1, 2'd1, 4'h1, 4'b1111, 1'b1, 4'b0010, 16'h0A10};
        vec[7]  = '{1'b1, 2'd2, 4'h2, 4'b1111, 1'b1, 4'b0100, 16'h0210};
        vec[8]  = '{1'b1, 2'd3, 4'h3, 4'b1111, 1'b1, 4'b1000, 16'h3210};
        vec[9]  = '{1'b1, 2'd0, 4'h4, 4'b1111, 1'b1, 4'b0001, 16'h3214};
        vec[10] = '{1'b1, 2'd1, 4'h5, 4'b1111, 1'b1, 4'b0010, 16'h3254};
        vec[11] = '{1'b1, 2'd2, 4'h6, 4'b1111, 1'b1, 4'b0100, 16'h3654};
        vec[12] = '{1'b1, 2'd3, 4'h7, 4'b1111, 1'b1, 4'b1000, 16'h7654};
        vec[13] = '{1'b1, 2'd3, 4'h5, 4'b0000, 1'b0, 4'b1000, 16'h7654};
        vec[14] = '{1'b1, 2'd3, 4'h5, 4'b1000, 1'b1, 4'b1000, 16'h5654};
        vec[15] = '{1'b0, 2'd3, 4'h0, 4'b1000, 1'b1, 4'b0000, 16'h5654};

        // Reset held with random inputs
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_sel   = 2'd0;
        set_rdy(4'b0000);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'($urandom);
            in_data  = 4'($urandom);
            in_sel   = 2'($urandom);
            set_rdy(4'($urandom));
            @(posedge clk);
            #1;
            check("reset_vld", {28'd0, vld_bus()}, 32'd0);
            check("reset_dat", {16'd0, dat_bus()}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        set_rdy(4'b0000);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        check("post_reset_vld", {28'd0, vld_bus()}, 32'd0);

        // Vector table: route, head-of-line block, streaming, back-pressure
        for (int i = 0; i < 16; i++) begin
            in_valid = vec[i].v;
            in_sel   = vec[i].sel;
            in_data  = vec[i].dat;
            set_rdy(vec[i].rdy);
            #1;
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vec[i].exp_ir});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_vld", i), {28'd0, vld_bus()}, {28'd0, vec[i].exp_vld});
            check($sformatf("vec%0d_dat", i), {16'd0, dat_bus()}, {16'd0, vec[i].exp_d});
        end

        // Mid-operation asynchronous reset
        set_rdy(4'b0000);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 4'h9;
        @(posedge clk);
        #1;
        in_sel  = 2'd1;
        in_data = 4'h6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("midrst_loaded", {28'd0, vld_bus()}, 32'h3);
        check("midrst_loaded_dat", {16'd0, dat_bus()}, 32'h5669);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_async_vld", {28'd0, vld_bus()}, 32'd0);
        check("midrst_async_dat", {16'd0, dat_bus()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_rdy(4'b1111);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("midrst_after_vld", {28'd0, vld_bus()}, 32'd0);
            check("midrst_after_dat", {16'd0, dat_bus()}, 32'd0);
        end

`ifdef STREAM_DEMUX_COUNT_EN
        // 260 handshakes on channel 0 wrap its counter to 4
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        set_rdy(4'b0001);
        in_sel   = 2'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 260; k++) begin
            in_data = 4'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("cnt0", {24'd0, cnt0}, 32'd4);
        check("cnt1", {24'd0, cnt1}, 32'd0);
        check("cnt2", {24'd0, cnt2}, 32'd0);
        check("cnt3", {24'd0, cnt3}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
